// File: rtl/ps2_receiver.sv
// PS/2 device-to-host deserializer: synchronize, deglitch, frame check, deliver byte.
// Latency: strobe/frame_error one cycle after the stop-bit edge cycle (raw fall + 2 + FILTER_LEN).
// Backpressure: none; strobes are at least one full PS/2 frame apart.
module ps2_receiver #(
    parameter int          FILTER_LEN = 4,
    parameter logic [15:0] TIMEOUT    = 16'd5000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       strobe,
    output logic       frame_error
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

    logic        clk_s1, clk_s2;
    logic        dat_s1, dat_s2;
    logic        filt_clk, filt_prev;
    logic [3:0]  filt_cnt;
    logic        fall;
    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        par_bit;
    logic [15:0] tcnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock only moves after FILTER_LEN unbroken mismatching samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= 4'd0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FILT_MAX) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= 4'd0;
                end else begin
                    filt_cnt <= filt_cnt + 4'd1;
                end
            end else begin
                filt_cnt <= 4'd0;
            end
        end
    end

    assign fall = filt_prev & ~filt_clk;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            par_bit     <= 1'b0;
            tcnt        <= 16'd0;
            scancode    <= 8'h00;
            strobe      <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            strobe      <= 1'b0;
            frame_error <= 1'b0;
            // Timeout wins over a coincident edge: the frame is already stale.
            if (state != S_IDLE && tcnt == TIMEOUT) begin
                state       <= S_IDLE;
                tcnt        <= 16'd0;
                frame_error <= 1'b1;
            end else if (fall) begin
                tcnt <= 16'd0;
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (dat_s2 && ((^shift) ^ par_bit)) begin
                            scancode <= shift;
                            strobe   <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state == S_IDLE) begin
                tcnt <= 16'd0;
            end else begin
                tcnt <= tcnt + 16'd1;
            end
        end
    end

endmodule
